// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI receive slice.
// No logic; pure declarations.
// Backpressure: n/a.
package spi_pkg;

    localparam int DEFAULT_DATA_W     = 12;
    localparam int DEFAULT_LEAD_EDGES = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_WAIT_CS
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall pulse detector.
// Latency: level 2 clk, edge pulses 3 clk after the pin transition.
// Backpressure: none; free-running sampler.
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= IDLE_VAL;
            s2   <= IDLE_VAL;
            prev <= IDLE_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
            rise <= s2 & ~prev;
            fall <= ~s2 & prev;
        end
    end

    assign level = s2;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: LSB-first frames into a 1-entry hold register.
// Latency: dout_valid rises 4 clk after the pin-level sclk fall carrying the last bit.
// Backpressure: dout_valid/dout_ready; a word completing while the hold register is full is dropped and overrun sticks.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LEAD_EDGES = DEFAULT_LEAD_EDGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int LEAD_W = (LEAD_EDGES > 0) ? $clog2(LEAD_EDGES + 1) : 1;
    localparam spi_state_t START_ST = (LEAD_EDGES == 0) ? ST_SHIFT : ST_LEAD;

    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;
    logic sclk_lvl_unused;
    logic sclk_rise_unused;
    logic cs_lvl_unused;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LEAD_W-1:0] lead_cnt;
    logic [LEAD_W-1:0] lead_cnt_inc;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] word_nxt;
    logic              lead_last;
    logic              frame_start;
    logic              frame_abort;
    logic              word_done;

    assign lead_cnt_inc = lead_cnt + 1'b1;
    assign lead_last    = (lead_cnt_inc == LEAD_W'(LEAD_EDGES));
    // A cs fall in WAIT_CS means the rising edge was missed: restart cleanly.
    assign frame_start  = cs_fall && (state == ST_IDLE || state == ST_WAIT_CS);
    assign frame_abort  = cs_rise && (state == ST_LEAD || state == ST_SHIFT);
    assign word_done    = (state == ST_SHIFT) && sclk_fall && !cs_rise &&
                          (bit_cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        word_nxt             = shift;
        word_nxt[DATA_W-1]   = mosi_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cs_fall) state_nxt = START_ST;
            end
            ST_LEAD: begin
                if (cs_rise)                     state_nxt = ST_IDLE;
                else if (sclk_fall && lead_last) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cs_rise)        state_nxt = ST_IDLE;
                else if (word_done) state_nxt = ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                if (cs_fall)      state_nxt = START_ST;
                else if (cs_rise) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        frame_err = 1'b0;
        if (!rst) begin
            busy      = (state != ST_IDLE);
            frame_err = frame_abort;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            lead_cnt   <= '0;
            shift      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_start || frame_abort) begin
                bit_cnt  <= '0;
                lead_cnt <= '0;
                shift    <= '0;
            end else if (state == ST_LEAD && sclk_fall) begin
                lead_cnt <= lead_cnt_inc;
            end else if (state == ST_SHIFT && sclk_fall) begin
                shift[bit_cnt] <= mosi_s;
                bit_cnt        <= bit_cnt + 1'b1;
            end

            // Completion wins over consumption so a same-clk handoff keeps dout_valid high.
            if (word_done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= word_nxt;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving bits per frame.
REQ-002 The block SHALL have parameter LEAD_EDGES, default 1, giving the number of sclk falling edges discarded after cs falls.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port sclk, input, 1, serial clock from master, asynchronous to clk.
REQ-006 The block SHALL have port cs, input, 1, chip select, active-low, asynchronous.
REQ-007 The block SHALL have port mosi, input, 1, serial data, LSB first, changed by master on sclk rising edge.
REQ-008 The block SHALL have port dout, output, DATA_W, last received word.
REQ-009 The block SHALL have port dout_valid, output, 1, dout holds an unconsumed word.
REQ-010 The block SHALL have port dout_ready, input, 1, consumer accepts dout when high with dout_valid.
REQ-011 The block SHALL have port busy, output, 1, a frame is in progress (state not IDLE).
REQ-012 The block SHALL have port frame_err, output, 1, one-clk pulse on truncated frame.
REQ-013 The block SHALL have port overrun, output, 1, sticky flag: a completed word was dropped.

Function
REQ-014 sclk, cs and mosi SHALL each pass a 2-flop synchronizer, followed by one edge-detect register for sclk and cs.
REQ-015 The FSM SHALL have states IDLE, LEAD, SHIFT and WAIT_CS.
REQ-016 IDLE SHALL go to LEAD on a synchronized cs falling edge, clearing the bit counter and the lead counter.
REQ-017 LEAD SHALL count sclk falling edges and go to SHIFT after LEAD_EDGES of them; if LEAD_EDGES is 0, IDLE SHALL go directly to SHIFT.
REQ-018 In SHIFT, each synchronized sclk falling edge SHALL write synchronized mosi into shift[bit_cnt] and increment bit_cnt (LSB first).
REQ-019 When the DATA_W-th bit is sampled, the FSM SHALL go to WAIT_CS and transfer the word to the output stage in the same clk.
REQ-020 WAIT_CS SHALL ignore further sclk edges and go to IDLE on a synchronized cs rising edge.
REQ-021 A cs rising edge in LEAD or SHIFT with bit_cnt < DATA_W SHALL pulse frame_err for exactly 1 clk, discard the partial word, and go to IDLE.
REQ-022 The output stage SHALL be a 1-entry hold register: dout is loaded and dout_valid is set on word completion; dout_valid clears on a clk with dout_valid and dout_ready both high.
REQ-023 If a word completes while dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL be unchanged, and overrun SHALL be set.
REQ-024 If a word completes in the same clk that dout_ready consumes the old word, the new word SHALL be loaded, dout_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-025 dout_valid SHALL rise exactly 4 clk cycles after the pin-level sclk falling edge that carries the last bit (2 sync + 1 edge + 1 output register).
REQ-026 A cs falling edge seen in WAIT_CS (no rising edge observed) SHALL be treated as a cs rising edge followed by a new frame start.
REQ-027 bit_cnt SHALL be $clog2(DATA_W+1) bits wide and SHALL never wrap.

Reset
REQ-028 While rst=1: state=IDLE, dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0, counters=0, shift=0, synchronizer flops = idle levels (sclk 0, cs 1, mosi 0).
REQ-029 rst asserted mid-frame SHALL abort the frame with no dout_valid or frame_err, and the next cs falling edge after rst deasserts SHALL start a clean frame.

Structure
REQ-030 Package spi_pkg SHALL hold the state enum type, the default DATA_W (12), and the default LEAD_EDGES (1).
REQ-031 Synchronizer plus edge detect SHALL be sub-module spi_sync_edge, instantiated once per input (edge outputs unused for mosi).

Verification
REQ-032 Driving 12'hA5C with the master timing (sclk toggling every 51 clk, cs low, mosi updated on rising edges, LSB first) SHALL give dout=12'hA5C, dout_valid high 4 clk after the 12th data falling edge, and frame_err=0.
REQ-033 Back-to-back frames 12'hFFF then 12'h001 with dout_ready held 1 SHALL give two valid words in order and overrun=0.
REQ-034 Two frames 12'h123 then 12'h456 with dout_ready=0 SHALL leave dout=12'h123 and overrun=1; then dout_ready=1 SHALL clear dout_valid and leave overrun=1.
REQ-035 Raising cs after 5 data bits SHALL pulse frame_err for 1 clk, assert no dout_valid, and return busy to 0.
REQ-036 Asserting rst for 2 clk after 7 bits, then sending a full frame 12'h0F0, SHALL give dout=12'h0F0 with no frame_err.
REQ-037 Sending 12'hABC with dout_ready pulsed in the exact clk the second word completes SHALL give dout=12'hABC, dout_valid continuously 1, and overrun=0.
